// File: rtl/nes_pkg.sv
// Shared NES bus constants and the sprite-DMA state encoding.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_REQ,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR   = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_controller.sv
// NES sprite DMA: copies CPU page $XX00-$XXFF into OAM via $2004 while the CPU is halted.
// Optional macro OAM_DMA_ALIGN_EN keeps every READ on a get (parity 0) cycle.
//
// state    | meaning
// IDLE     | CPU runs, bus released, waiting for a $4014 write
// HALT_REQ | cpu_rdy low, waiting for cpu_halted
// ALIGN    | one idle bus cycle so the first READ lands on a get cycle
// READ     | drive {page, index}, capture the returned byte
// WRITE    | drive the captured byte to $2004, advance index
module oam_dma_controller
  import nes_pkg::*;
(
  input  logic        cpu_clock,
  input  logic        reset_n,
  input  logic        reg_write_strobe,
  input  logic [7:0]  reg_write_data,
  input  logic        cpu_halted,
  output logic        cpu_rdy,
  output logic        bus_owner,
  output logic [15:0] bus_address,
  output logic        bus_read_n,
  output logic        bus_write_n,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  OAMDMA_reg,
  output logic [7:0]  OAMDMA_reg_active
);

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       align_needed;

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) parity_q <= 1'b0;
    else          parity_q <= ~parity_q;
  end

  // Current get cycle means the next one is a put, so the READ must wait one cycle.
  assign align_needed = ~parity_q;
`else
  assign align_needed = 1'b0;
`endif

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      page_q  <= 8'h00;
      index_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reg_write_strobe) begin
          page_d  = reg_write_data;
          index_d = 8'h00;
          state_d = ST_HALT_REQ;
        end
      end
      ST_HALT_REQ: begin
        if (cpu_halted) state_d = align_needed ? ST_ALIGN : ST_READ;
      end
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        data_d  = bus_data_in;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (index_q == 8'hFF) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_owner    = 1'b0;
    bus_read_n   = 1'b1;
    bus_write_n  = 1'b1;
    bus_address  = 16'h0000;
    bus_data_out = 8'h00;
    case (state_q)
      ST_ALIGN: bus_owner = 1'b1;
      ST_READ: begin
        bus_owner   = 1'b1;
        bus_read_n  = 1'b0;
        bus_address = {page_q, index_q};
      end
      ST_WRITE: begin
        bus_owner    = 1'b1;
        bus_write_n  = 1'b0;
        bus_address  = OAM_DATA_ADDR;
        bus_data_out = data_q;
      end
      default: ;
    endcase
  end

  assign cpu_rdy           = (state_q == ST_IDLE);
  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign OAMDMA_reg        = 8'h00;
  assign OAMDMA_reg_active = 8'h00;

  a_halt_held: assert property (@(posedge cpu_clock) disable iff (!reset_n)
    (state_q inside {ST_ALIGN, ST_READ, ST_WRITE}) |-> cpu_halted)
    else $error("cpu_halted dropped while the DMA owned the bus");

endmodule
